// File: rtl/tia_framebuffer.sv
// Captures TIA pixel stream into a WIDTH x HEIGHT frame store and serves
// registered reads to the display stage.
module tia_framebuffer #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 240,
  parameter int VSKIP  = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tia_vsync,
  input  logic        tia_hsync,
  input  logic        tia_pix_valid,
  input  logic [6:0]  tia_color,
  input  logic [15:0] vga_addr,
  output logic [6:0]  vga_data,
  output logic        frame_done,
  output logic        line_overflow
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [16:0] DEPTH_L   = 17'(DEPTH);
  localparam logic [7:0]  X_MAX     = 8'(WIDTH);
  localparam logic [7:0]  Y_LAST    = 8'(HEIGHT - 1);
  localparam logic [15:0] LINE_STEP = 16'(WIDTH);
  localparam logic [15:0] SKIP_LAST = 16'((VSKIP > 0) ? VSKIP - 1 : 0);

  typedef enum logic [2:0] {IDLE, VSYNC, SKIP, ACTIVE, DONE} state_t;

  state_t      state;
  logic        vsync_q, hsync_q;
  logic [7:0]  x, y;
  logic [15:0] line_cnt;
  logic [15:0] wr_addr, line_base;

  logic        vs_rise, vs_fall, hs_rise;
  logic [15:0] next_base;
  logic        wr_en;
  logic [15:0] wr_sel;

  logic [6:0]  mem [DEPTH];

  assign vs_rise = tia_vsync & ~vsync_q;
  assign vs_fall = ~tia_vsync & vsync_q;
  assign hs_rise = tia_hsync & ~hsync_q;

  // A pixel arriving with the hsync edge belongs to x=0 of the next line.
  always_comb begin
    next_base = line_base + LINE_STEP;
    wr_en     = 1'b0;
    wr_sel    = wr_addr;
    if (!reset && !vs_rise && state == ACTIVE && tia_pix_valid) begin
      if (hs_rise) begin
        if (y != Y_LAST) begin
          wr_en  = 1'b1;
          wr_sel = next_base;
        end
      end else if (x < X_MAX) begin
        wr_en = 1'b1;
      end
    end
    if ({1'b0, wr_sel} >= DEPTH_L) wr_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_sel[AW-1:0]] <= tia_color;
  end

  // Read-before-write: the read samples the array before this edge's write.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_data <= '0;
    end else if ({1'b0, vga_addr} < DEPTH_L) begin
      vga_data <= mem[vga_addr[AW-1:0]];
    end else begin
      vga_data <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      vsync_q       <= 1'b0;
      hsync_q       <= 1'b0;
      x             <= '0;
      y             <= '0;
      line_cnt      <= '0;
      wr_addr       <= '0;
      line_base     <= '0;
      frame_done    <= 1'b0;
      line_overflow <= 1'b0;
    end else begin
      vsync_q    <= tia_vsync;
      hsync_q    <= tia_hsync;
      frame_done <= 1'b0;
      if (vs_rise) begin
        state <= VSYNC;
      end else begin
        case (state)
          IDLE: ;
          VSYNC: begin
            if (vs_fall) begin
              line_cnt <= '0;
              if (VSKIP == 0) begin
                state     <= ACTIVE;
                x         <= '0;
                y         <= '0;
                line_base <= '0;
                wr_addr   <= '0;
              end else begin
                state <= SKIP;
              end
            end
          end
          SKIP: begin
            if (hs_rise) begin
              line_cnt <= line_cnt + 16'd1;
              if (line_cnt == SKIP_LAST) begin
                state     <= ACTIVE;
                x         <= '0;
                y         <= '0;
                line_base <= '0;
                wr_addr   <= '0;
              end
            end
          end
          ACTIVE: begin
            if (hs_rise) begin
              if (y == Y_LAST) begin
                frame_done <= 1'b1;
                state      <= DONE;
              end else begin
                line_base <= next_base;
                y         <= y + 8'd1;
                if (tia_pix_valid) begin
                  x       <= 8'd1;
                  wr_addr <= next_base + 16'd1;
                end else begin
                  x       <= '0;
                  wr_addr <= next_base;
                end
              end
            end else if (tia_pix_valid) begin
              if (x < X_MAX) begin
                x       <= x + 8'd1;
                wr_addr <= wr_addr + 16'd1;
              end else begin
                line_overflow <= 1'b1;
              end
            end
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tia_framebuffer.sv
// Scoreboard bench for tia_framebuffer: directed frame scenarios followed by
// randomized sync/pixel/read traffic checked against a frame-level model.
module tb_tia_framebuffer;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int VS    = 1;
  localparam int DEPTH = W * H;

  localparam int PH_IDLE = 0;
  localparam int PH_SYNC = 1;
  localparam int PH_SKIP = 2;
  localparam int PH_ACT  = 3;
  localparam int PH_DONE = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tia_vsync = 1'b0;
  logic        tia_hsync = 1'b0;
  logic        tia_pix_valid = 1'b0;
  logic [6:0]  tia_color = '0;
  logic [15:0] vga_addr = '0;
  logic [6:0]  vga_data;
  logic        frame_done;
  logic        line_overflow;

  always #5 clk = ~clk;

  tia_framebuffer #(.WIDTH(W), .HEIGHT(H), .VSKIP(VS)) dut (
    .clk(clk),
    .reset(reset),
    .tia_vsync(tia_vsync),
    .tia_hsync(tia_hsync),
    .tia_pix_valid(tia_pix_valid),
    .tia_color(tia_color),
    .vga_addr(vga_addr),
    .vga_data(vga_data),
    .frame_done(frame_done),
    .line_overflow(line_overflow)
  );

  typedef struct packed {
    logic [31:0] step;
    logic        rd;
    logic [6:0]  data;
    logic        fd;
    logic        ovf;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   step_no = 0;

  // Frame-level reference model: phase, skipped-line count, row/column.
  logic [6:0] m_mem [DEPTH];
  int         m_phase = PH_IDLE;
  int         m_skipped = 0;
  int         m_row = 0;
  int         m_col = 0;
  logic       m_ovf = 1'b0;
  logic       m_pvs = 1'b0;
  logic       m_phs = 1'b0;

  logic        cur_vs = 1'b0, cur_hs = 1'b0;
  logic        rq_en = 1'b0, rq_fixed = 1'b0;
  logic [15:0] rq_addr = '0;
  logic [6:0]  rq_val = '0;

  task automatic check(input string name, input int stp, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s step=%0d got=%0h want=%0h", name, stp, act, want);
    end
  endtask

  function automatic logic model_step(input logic r, input logic v, input logic h,
                                      input logic p, input logic [6:0] c);
    logic vr, vf, hr, fd;
    fd = 1'b0;
    if (r) begin
      m_phase = PH_IDLE;
      m_ovf   = 1'b0;
      m_pvs   = 1'b0;
      m_phs   = 1'b0;
      return 1'b0;
    end
    vr = v & ~m_pvs;
    vf = ~v & m_pvs;
    hr = h & ~m_phs;
    m_pvs = v;
    m_phs = h;
    if (vr) begin
      m_phase = PH_SYNC;
    end else begin
      case (m_phase)
        PH_SYNC: if (vf) begin
          m_skipped = 0;
          if (VS == 0) begin m_phase = PH_ACT; m_row = 0; m_col = 0; end
          else m_phase = PH_SKIP;
        end
        PH_SKIP: if (hr) begin
          m_skipped++;
          if (m_skipped == VS) begin m_phase = PH_ACT; m_row = 0; m_col = 0; end
        end
        PH_ACT: begin
          if (hr) begin
            if (m_row == H - 1) begin
              fd = 1'b1;
              m_phase = PH_DONE;
            end else begin
              m_row++;
              m_col = 0;
              if (p) begin
                m_mem[m_row * W] = c;
                m_col = 1;
              end
            end
          end else if (p) begin
            if (m_col < W) begin
              m_mem[m_row * W + m_col] = c;
              m_col++;
            end else begin
              m_ovf = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
    return fd;
  endfunction

  // One clock of stimulus; the expectation for this cycle is queued.
  task automatic drive(input logic r, input logic v, input logic h, input logic p, input logic [6:0] c);
    exp_t e;
    @(negedge clk);
    reset = r;
    tia_vsync = v;
    tia_hsync = h;
    tia_pix_valid = p;
    tia_color = c;
    vga_addr = rq_addr;
    step_no++;
    e.step = step_no;
    e.rd = rq_en | r;
    if (r) e.data = '0;
    else if (rq_fixed) e.data = rq_val;
    else if (rq_addr < DEPTH) e.data = m_mem[rq_addr];
    else e.data = '0;
    e.fd = model_step(r, v, h, p, c);
    e.ovf = m_ovf;
    cur_vs = v;
    cur_hs = h;
    q.push_back(e);
    rq_en = 1'b0;
    rq_fixed = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, cur_vs, cur_hs, 1'b0, 7'h00);
  endtask

  task automatic pix(input logic [6:0] c);
    drive(1'b0, cur_vs, cur_hs, 1'b1, c);
  endtask

  task automatic hedge(input logic p, input logic [6:0] c);
    drive(1'b0, cur_vs, 1'b1, p, c);
    drive(1'b0, cur_vs, 1'b0, 1'b0, 7'h00);
  endtask

  task automatic start_frame();
    drive(1'b0, 1'b1, cur_hs, 1'b0, 7'h00);
    drive(1'b0, 1'b1, cur_hs, 1'b0, 7'h00);
    drive(1'b0, 1'b0, cur_hs, 1'b0, 7'h00);
    hedge(1'b0, 7'h00);
  endtask

  task automatic rd(input logic [15:0] a, input logic [6:0] v);
    rq_en = 1'b1;
    rq_fixed = 1'b1;
    rq_addr = a;
    rq_val = v;
    idle(1);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("frame_done", e.step, 32'(frame_done), 32'(e.fd));
        check("line_overflow", e.step, 32'(line_overflow), 32'(e.ovf));
        if (e.rd) check("vga_data", e.step, 32'(vga_data), 32'(e.data));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog step=%0d got=running want=finished", step_no);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic v, h, r;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 7'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 7'h00);
    idle(2);

    // Basic frame: lines of 1..4 and 5..8, frame_done on third hsync edge.
    start_frame();
    for (int i = 1; i <= 4; i++) pix(7'(i));
    hedge(1'b0, 7'h00);
    for (int i = 5; i <= 8; i++) pix(7'(i));
    hedge(1'b0, 7'h00);
    pix(7'h3F);
    for (int i = 0; i < DEPTH; i++) rd(16'(i), 7'(i + 1));
    rd(16'(DEPTH), 7'h00);
    rd(16'hFFFF, 7'h00);

    // hsync edge with a coincident pixel lands at the new line base.
    start_frame();
    repeat (4) pix(7'h11);
    hedge(1'b1, 7'h55);
    pix(7'h66); pix(7'h67); pix(7'h68);
    hedge(1'b0, 7'h00);
    rd(16'd3, 7'h11);
    rd(16'd4, 7'h55);
    rd(16'd7, 7'h68);

    // Read/write collision at address 3, then an over-long line.
    start_frame();
    pix(7'h30); pix(7'h31); pix(7'h32);
    rq_en = 1'b1; rq_fixed = 1'b1; rq_addr = 16'd3; rq_val = 7'h11;
    pix(7'h22);
    rd(16'd3, 7'h22);
    hedge(1'b0, 7'h00);
    repeat (4) pix(7'h09);
    pix(7'h7F);
    hedge(1'b0, 7'h00);
    for (int i = 4; i < 8; i++) rd(16'(i), 7'h09);
    rd(16'(DEPTH), 7'h00);
    idle(3);

    // vsync mid-frame at y=1: partial frame abandoned, pixels ignored until skip completes.
    start_frame();
    pix(7'h41); pix(7'h42); pix(7'h43); pix(7'h44);
    hedge(1'b0, 7'h00);
    pix(7'h45);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 7'h46);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 7'h47);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 7'h48);
    pix(7'h49);
    hedge(1'b1, 7'h4A);
    pix(7'h50); pix(7'h51); pix(7'h52); pix(7'h53);
    rd(16'd4, 7'h45);
    rd(16'd5, 7'h09);
    rd(16'd0, 7'h50);
    rd(16'd1, 7'h51);
    rd(16'd3, 7'h53);

    // Reset mid-line with a pixel present; IDLE then ignores traffic.
    start_frame();
    pix(7'h60);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 7'h61);
    pix(7'h62);
    hedge(1'b1, 7'h63);
    rd(16'd0, 7'h60);
    rd(16'd1, 7'h51);
    start_frame();
    pix(7'h70);
    rd(16'd0, 7'h70);

    // Randomized sync, pixel, reset and read traffic.
    for (int i = 0; i < 2500; i++) begin
      v = cur_vs;
      h = cur_hs;
      r = 1'b0;
      if (!cur_vs && $urandom_range(0, 59) == 0) v = 1'b1;
      else if (cur_vs && $urandom_range(0, 2) == 0) v = 1'b0;
      if ($urandom_range(0, 4) == 0) h = ~cur_hs;
      if ($urandom_range(0, 599) == 0) r = 1'b1;
      if ($urandom_range(0, 1) == 1) begin
        rq_en = 1'b1;
        rq_addr = 16'($urandom_range(0, DEPTH + 2));
      end
      drive(r, v, h, 1'($urandom_range(0, 1)), 7'($urandom));
    end

    idle(2);
    @(posedge clk);
    #3;
    check("drain", step_no, 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tia_framebuffer.md
TIA_FRAMEBUFFER -- requirements
Module: tia_framebuffer

Interface
REQ-001 SHALL have parameter WIDTH, default 160, meaning stored pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 240, meaning stored lines per frame.
REQ-003 SHALL have parameter VSKIP, default 30, meaning lines discarded after VSYNC ends, before storage starts.
REQ-004 SHALL have port clk, input, 1, meaning the single clock for all logic.
REQ-005 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port tia_vsync, input, 1, meaning the TIA VSYNC level.
REQ-007 SHALL have port tia_hsync, input, 1, meaning the TIA line sync level; a rising edge starts a line.
REQ-008 SHALL have port tia_pix_valid, input, 1, meaning tia_color carries one visible pixel this cycle.
REQ-009 SHALL have port tia_color, input, 7, meaning the palette index of the pixel.
REQ-010 SHALL have port vga_addr, input, 16, meaning the read address (y*WIDTH+x) from the display stage.
REQ-011 SHALL have port vga_data, output, 7, meaning the registered read data.
REQ-012 SHALL have port frame_done, output, 1, meaning a one-cycle pulse when line HEIGHT-1 completes.
REQ-013 SHALL have port line_overflow, output, 1, meaning sticky: some line received more than WIDTH pixels.

Function
REQ-014 SHALL hold WIDTH*HEIGHT 7-bit entries in a memory with one write port and one read port, both on clk.
REQ-015 SHALL drive vga_data from mem[vga_addr] one clk after vga_addr is presented.
REQ-016 SHALL drive vga_data to 0 when vga_addr >= WIDTH*HEIGHT.
REQ-017 SHALL, when a read and a write hit the same address in the same cycle, return the old data (read-before-write).
REQ-018 SHALL detect edges by registering tia_vsync and tia_hsync once; an edge is current != previous registered value.
REQ-019 SHALL implement states IDLE, VSYNC, SKIP, ACTIVE and DONE.
REQ-020 IDLE SHALL go to VSYNC on a tia_vsync rising edge; all pixels are ignored in IDLE.
REQ-021 VSYNC SHALL go to SKIP on a tia_vsync falling edge, clearing line_cnt to 0.
REQ-022 SKIP SHALL increment line_cnt on each hsync rising edge.
REQ-023 SKIP SHALL, on the edge where line_cnt == VSKIP-1, go to ACTIVE with y=0, x=0, line_base=0 and wr_addr=0.
REQ-024 SHALL, when VSKIP=0, go directly from VSYNC to ACTIVE.
REQ-025 ACTIVE SHALL, per tia_pix_valid with x < WIDTH, write tia_color to wr_addr, then increment x and wr_addr.
REQ-026 ACTIVE SHALL, on tia_pix_valid with x == WIDTH, drop the pixel and set line_overflow.
REQ-027 ACTIVE SHALL, on an hsync rising edge, set line_base += WIDTH, wr_addr = new line_base, x=0 and y += 1.
REQ-028 ACTIVE SHALL derive addresses by this increment only; no multiplier SHALL be used.
REQ-029 SHALL, on an hsync rising edge with tia_pix_valid in the same cycle, write that pixel as x=0 of the new line.
REQ-030 ACTIVE SHALL, on the hsync rising edge when y == HEIGHT-1, pulse frame_done for 1 cycle and go to DONE without writing.
REQ-031 DONE SHALL ignore pixels and hsync.
REQ-032 SHALL, in any state, go to VSYNC on a tia_vsync rising edge and abandon a partial frame; memory is retained.
REQ-033 SHALL ignore pixels while in VSYNC and SKIP.
REQ-034 SHALL size x to 8 bits, y to 8 bits and wr_addr/line_base to 16 bits; no wrap-around is reachable with the defaults.

Reset
REQ-035 SHALL, on reset, force state=IDLE, x=y=line_cnt=0, wr_addr=line_base=0, frame_done=0, line_overflow=0, vga_data=0 and the edge registers=0.
REQ-036 SHALL NOT clear memory contents on reset.
REQ-037 SHALL, on reset asserted mid-line, suppress any write in that cycle.
REQ-038 SHALL clear line_overflow only on reset.

Verification
REQ-039 Bench SHALL run WIDTH=4, HEIGHT=2, VSKIP=1: vsync pulse, 1 skip line, 2 lines of colours 1..4 then 5..8 -> mem[0..7]=1..8, and frame_done pulses once at the third hsync edge.
REQ-040 Bench SHALL drive 5 pixels (9,9,9,9,0x7F) in one line -> the 5th is dropped, mem[x=0..3]=9, line_overflow=1 and stays 1 until reset.
REQ-041 Bench SHALL assert hsync edge and pix_valid with colour 0x55 in the same cycle -> mem[line_base_new]=0x55.
REQ-042 Bench SHALL drive a vsync rising edge mid-ACTIVE at y=1 -> state VSYNC, no frame_done, subsequent pixels not written until the next SKIP completes.
REQ-043 Bench SHALL set vga_addr=3 on the same cycle a write of 0x22 hits address 3 (old value 0x11) -> vga_data=0x11 next cycle and 0x22 one cycle later; vga_addr=WIDTH*HEIGHT -> vga_data=0.
REQ-044 Bench SHALL assert reset during ACTIVE with pix_valid=1 -> no write that cycle, outputs at reset values, IDLE ignores pixels until a vsync rising edge.
